// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, default
// memory size and the word-address legality rule.
package dmem_pkg;

    localparam int unsigned MEM_BYTES_DEF = 44;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // Word-aligned and the whole word fits inside the memory. The address is
    // compared at full width so high bits are never silently dropped.
    function automatic logic word_legal(input logic [63:0] addr,
                                        input int unsigned mem_bytes);
        return (addr[1:0] == 2'b00) && (addr <= 64'(mem_bytes - 4));
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester handshakes and memory bus of the data-memory arbiter.
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              r0_req;
    logic              r0_we;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_wdata;
    logic              r0_gnt;
    logic              r0_rvalid;
    logic [DATA_W-1:0] r0_rdata;
    logic              r0_err;

    logic              r1_req;
    logic              r1_we;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_wdata;
    logic              r1_gnt;
    logic              r1_rvalid;
    logic [DATA_W-1:0] r1_rdata;
    logic              r1_err;

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_write;
    logic              mem_read;
    logic [DATA_W-1:0] mem_read_data;

    // Arbiter side
    modport slave (
        input  r0_req, r0_we, r0_addr, r0_wdata,
        output r0_gnt, r0_rvalid, r0_rdata, r0_err,
        input  r1_req, r1_we, r1_addr, r1_wdata,
        output r1_gnt, r1_rvalid, r1_rdata, r1_err,
        output mem_address, mem_write_data, mem_write, mem_read,
        input  mem_read_data
    );

    // Requesters plus memory side
    modport master (
        output r0_req, r0_we, r0_addr, r0_wdata,
        input  r0_gnt, r0_rvalid, r0_rdata, r0_err,
        output r1_req, r1_we, r1_addr, r1_wdata,
        input  r1_gnt, r1_rvalid, r1_rdata, r1_err,
        input  mem_address, mem_write_data, mem_write, mem_read,
        output mem_read_data
    );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin picker. The pointer names the requester that wins a
// tie; after a contested pick it moves to the loser.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] grant_o
);
    logic ptr_q, ptr_d;

    // One-hot pick and pointer update
    always_comb begin
        grant_o = 2'b00;
        ptr_d   = ptr_q;
        case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11: begin
                grant_o = ptr_q ? 2'b10 : 2'b01;
                if (advance_i) ptr_d = ~ptr_q;
            end
            default: grant_o = 2'b00;
        endcase
    end

    // Priority pointer register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= 1'b0;
        else     ptr_q <= ptr_d;
    end
endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and one-word access sequencer for the single-port data
// memory. Grant, one access cycle, then a response cycle that also hosts the
// next arbitration.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MEM_BYTES = MEM_BYTES_DEF
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);
    state_e            state_q, state_d;
    logic              cmd_we_q, cmd_we_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
    logic              owner_q, owner_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic [1:0] req;
    logic [1:0] grant;
    logic [1:0] gnt;
    logic       arb_slot;
    logic       legal;

    assign req      = {bus.r1_req, bus.r0_req};
    // No grants while reset is held, so nothing is issued during reset.
    assign arb_slot = (state_q != ST_ACCESS) && !rst;
    assign gnt      = grant & {2{arb_slot}};
    assign legal    = word_legal(64'(cmd_addr_q), MEM_BYTES);

    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req),
        .advance_i (arb_slot),
        .grant_o   (grant)
    );

    // Next-state, command capture and decoded outputs
    always_comb begin
        state_d     = state_q;
        cmd_we_d    = cmd_we_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        owner_d     = owner_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;

        bus.mem_write = 1'b0;
        bus.mem_read  = 1'b0;
        bus.r0_rvalid = 1'b0;
        bus.r1_rvalid = 1'b0;
        bus.r0_err    = 1'b0;
        bus.r1_err    = 1'b0;

        case (state_q)
            ST_ACCESS: begin
                bus.mem_write = cmd_we_q & legal;
                bus.mem_read  = ~cmd_we_q & legal;
                if (owner_q) rdata1_d = (!cmd_we_q && legal) ? bus.mem_read_data : '0;
                else         rdata0_d = (!cmd_we_q && legal) ? bus.mem_read_data : '0;
                state_d = ST_RESP;
            end
            default: begin
                if (state_q == ST_RESP) begin
                    bus.r0_rvalid = ~owner_q;
                    bus.r1_rvalid = owner_q;
                    bus.r0_err    = ~owner_q & ~legal;
                    bus.r1_err    = owner_q & ~legal;
                end
                if (gnt[1]) begin
                    cmd_we_d    = bus.r1_we;
                    cmd_addr_d  = bus.r1_addr;
                    cmd_wdata_d = bus.r1_wdata;
                    owner_d     = 1'b1;
                    state_d     = ST_ACCESS;
                end else if (gnt[0]) begin
                    cmd_we_d    = bus.r0_we;
                    cmd_addr_d  = bus.r0_addr;
                    cmd_wdata_d = bus.r0_wdata;
                    owner_d     = 1'b0;
                    state_d     = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // State, command and read-data registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            owner_q     <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            state_q     <= state_d;
            cmd_we_q    <= cmd_we_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            owner_q     <= owner_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    assign bus.r0_gnt         = gnt[0];
    assign bus.r1_gnt         = gnt[1];
    assign bus.r0_rdata       = rdata0_q;
    assign bus.r1_rdata       = rdata1_q;
    assign bus.mem_address    = cmd_addr_q;
    assign bus.mem_write_data = cmd_wdata_q;
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and access sequencer in front of the single-port, byte-addressed, big-endian data memory (44 bytes, word accesses).
- Requester 0 is the core load/store path. Requester 1 is the debug/loader port.
- Grants one word access at a time using round-robin.
- Drives the memory's address, write-data, write-enable and read-enable, and returns registered read data.
- Range and alignment checking happens before the memory is touched.

Parameters:
- ADDR_W, 32, address width of requester and memory ports
- DATA_W, 32, word width
- MEM_BYTES, 44, memory size in bytes; legal word addresses are 0 to MEM_BYTES-4, step 4

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- r0_req  in  1  requester 0 access request; held until r0_gnt
- r0_we  in  1  1 = store, 0 = load
- r0_addr  in  ADDR_W  byte address
- r0_wdata  in  DATA_W  store data
- r0_gnt  out  1  one-cycle pulse: request accepted, fields may change next cycle
- r0_rvalid  out  1  one-cycle pulse: access completed (load or store)
- r0_rdata  out  DATA_W  load data, valid with r0_rvalid
- r0_err  out  1  with r0_rvalid: access rejected (misaligned or out of range)
- r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata, r1_err  same as requester 0, for requester 1
- mem_address  out  ADDR_W  to memory Address
- mem_write_data  out  DATA_W  to memory WriteData
- mem_write  out  1  to memory MemWrite
- mem_read  out  1  to memory MemRead
- mem_read_data  in  DATA_W  from memory ReadData (combinational)

Behaviour:
- Reset (asynchronous) values:
  - State = IDLE; priority pointer = requester 0.
  - All gnt/rvalid/err/mem_write/mem_read = 0; rdata and mem_address/mem_write_data = 0.
- FSM states: IDLE, ACCESS, RESP.
- Arbitration in IDLE or RESP:
  - If any req is high, pick a winner.
  - If only one requester is asking, it wins.
  - If both are asking, the requester named by the pointer wins, then the pointer flips to the loser.
  - The winner's gnt pulses in that cycle. Its we/addr/wdata are latched into cmd registers and the FSM goes to ACCESS.
- ACCESS (exactly one cycle):
  - mem_address = latched addr.
  - mem_write = latched we & legal.
  - mem_read = ~latched we & legal.
  - legal = (addr[1:0]==0) && (addr <= MEM_BYTES-4), computed on the latched address with no truncation.
  - The memory write commits at the rising edge ending ACCESS.
  - For loads, mem_read_data is captured into the owner's rdata register at the same edge.
  - Next state = RESP.
- RESP:
  - Owner's rvalid = 1 for one cycle; err = ~legal.
  - On err or store, rdata = 0.
  - rdata holds its value until the next completion for that requester.
  - Arbitration for the next access happens in this same cycle. With continuous requests, throughput is one access per 2 cycles.
  - If no req is high, next state = IDLE.
- Latency: gnt at cycle T, memory access at T+1, rvalid at T+2.
- Outputs outside ACCESS: mem_write = mem_read = 0 (combinational decode of state). mem_address and mem_write_data hold the last latched values.
- An illegal access never asserts mem_write or mem_read; memory contents are unchanged.
- A requester dropping req before gnt withdraws the request; no response is produced.
- A req still high in the cycle after gnt counts as a new request. Requesters must drop req on gnt unless they intend back-to-back accesses.
- Reset asserted mid-ACCESS:
  - mem_write drops immediately (asynchronous). Whether the memory write lands is undefined.
  - No rvalid is issued for the aborted access.
- The memory's own initialisation input is outside this block. The arbiter issues no accesses while rst is high.

Decomposition:
- Shared package dmem_pkg:
  - FSM state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2)
  - MEM_BYTES default
  - a legal-word-address function
- One natural sub-module: rr_arb2, a 2-way round-robin picker with inputs req[1:0] and advance, and output one-hot grant[1:0], containing the pointer flop.

Test Plan:
- Single load: r0 load addr 8 from the initialised memory -> r0_gnt at T, mem_read=1 and mem_address=8 at T+1, r0_rvalid at T+2 with r0_rdata=32'h3, r0_err=0.
- Store then load: r1 store 32'hDEADBEEF at addr 40, then r1 load addr 40 -> r1_rdata=32'hDEADBEEF; load of addr 36 still returns 32'hA.
- Contention: r0 and r1 both request continuously for 4 accesses -> grants alternate r0,r1,r0,r1; one rvalid every 2 cycles; no cycle has both gnts high.
- Illegal address: r0 store to addr 6, then addr 44 -> both complete with r0_err=1, mem_write never asserted, and loads of addr 4 and addr 40 return their prior values.
- Reset mid-operation: assert rst during the ACCESS of an r1 store -> all outputs 0 at once, no r1_rvalid; after release, an r0 request is granted first.
- Load of addr 0 -> r0_rdata=32'hFFFFFFFB (-5).
